// File: rtl/hazard_stall_unit.sv
// Decode-side hazard controller: stalls on load-use and holds EX for multi-cycle FPU ops.
// Stall/flush outputs are Mealy (state + current inputs); state, cnt and stall_count are registered.
module hazard_stall_unit #(
    parameter int unsigned FPU_LATENCY = 4,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic [4:0]       ID_frs3,
    input  logic             ID_useRs1,
    input  logic             ID_useRs2,
    input  logic             ID_useFrs3,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_f_MemRead,
    input  logic             EX_fpuMulti,
    input  logic             branch_taken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EX_Hold,
    output logic             EXMEM_Bubble,
    output logic             fpu_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        FPU_WAIT = 1'b1
    } state_t;

    // The entry cycle already counts as one hold cycle, and the last wait cycle releases.
    localparam logic [3:0] CNT_INIT = 4'(FPU_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [4:0] src_idx [3];
    logic [2:0] src_use;
    logic [2:0] src_hit;
    logic       any_hit;
    logic       lu;

    logic pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, exmem_bubble, busy;

    assign src_idx[0] = ID_Rs1;
    assign src_idx[1] = ID_Rs2;
    assign src_idx[2] = ID_frs3;
    assign src_use    = {ID_useFrs3, ID_useRs2, ID_useRs1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src_cmp
            assign src_hit[gi] = src_use[gi] && (src_idx[gi] == EX_Rd);
        end
    endgenerate

    assign any_hit = |src_hit;
    // f0 is a real FP register, so only integer loads get the x0 exclusion.
    assign lu = (EX_MemRead && (EX_Rd != 5'd0) && any_hit) || (EX_f_MemRead && any_hit);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        ex_hold      = 1'b0;
        exmem_bubble = 1'b0;
        busy         = 1'b0;

        case (state_q)
            RUN: begin
                if (EX_fpuMulti) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    state_d      = FPU_WAIT;
                    cnt_d        = CNT_INIT;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            FPU_WAIT: begin
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    ex_hold      = 1'b1;
                    exmem_bubble = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // Reset releases the pipeline in the same cycle, whatever the FSM was doing.
        if (!rst_n) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            ex_hold      = 1'b0;
            exmem_bubble = 1'b0;
            busy         = 1'b0;
            state_d      = RUN;
            cnt_d        = 4'd0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign PC_Write     = pc_write;
    assign IFID_Write   = ifid_write;
    assign IFID_Flush   = ifid_flush;
    assign IDEX_Flush   = idex_flush;
    assign EX_Hold      = ex_hold;
    assign EXMEM_Bubble = exmem_bubble;
    assign fpu_busy     = busy;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: a full-width and a 4-bit-counter instance share stimulus.
module tb_hazard_stall_unit;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, frs3, rd;
    logic       use1, use2, use3, mr, fmr, fm, br;

    logic        pc_w, ifid_w, ifid_f, idex_f, ex_h, exmem_b, busy;
    logic [31:0] sc32;
    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_ex_h, s_exmem_b, s_busy;
    logic [3:0]  sc4;

    always #5 clk = ~clk;

    hazard_stall_unit #(.FPU_LATENCY(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(rs1), .ID_Rs2(rs2), .ID_frs3(frs3),
        .ID_useRs1(use1), .ID_useRs2(use2), .ID_useFrs3(use3),
        .EX_Rd(rd), .EX_MemRead(mr), .EX_f_MemRead(fmr), .EX_fpuMulti(fm),
        .branch_taken(br),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .IFID_Flush(ifid_f), .IDEX_Flush(idex_f),
        .EX_Hold(ex_h), .EXMEM_Bubble(exmem_b), .fpu_busy(busy), .stall_count(sc32)
    );

    hazard_stall_unit #(.FPU_LATENCY(LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs1(rs1), .ID_Rs2(rs2), .ID_frs3(frs3),
        .ID_useRs1(use1), .ID_useRs2(use2), .ID_useFrs3(use3),
        .EX_Rd(rd), .EX_MemRead(mr), .EX_f_MemRead(fmr), .EX_fpuMulti(fm),
        .branch_taken(br),
        .PC_Write(s_pc_w), .IFID_Write(s_ifid_w), .IFID_Flush(s_ifid_f), .IDEX_Flush(s_idex_f),
        .EX_Hold(s_ex_h), .EXMEM_Bubble(s_exmem_b), .fpu_busy(s_busy), .stall_count(sc4)
    );

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic [31:0] cnt;
        logic [3:0]  cnt_sat;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model: m_rem counts remaining FPU_WAIT cycles, the last of which releases.
    logic        m_wait;
    int          m_rem;
    int unsigned m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1;
        rs1 = 5'd0; rs2 = 5'd0; frs3 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; use3 = 1'b0;
        mr = 1'b0; fmr = 1'b0; fm = 1'b0; br = 1'b0;
    endtask

    task automatic step(input string tag);
        exp_t       e;
        exp_t       got_e;
        logic       hit, lu_m;
        logic [6:0] c;
        hit  = (use1 && rs1 == rd) || (use2 && rs2 == rd) || (use3 && frs3 == rd);
        lu_m = hit && ((mr && rd != 5'd0) || fmr);
        // ctrl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EX_Hold, EXMEM_Bubble, fpu_busy}
        c = 7'b1100000;
        if (rst_n) begin
            if (m_wait)      c = (m_rem > 1) ? 7'b0000111 : 7'b1100001;
            else if (fm)     c = 7'b0000110;
            else if (br)     c = 7'b1111000;
            else if (lu_m)   c = 7'b0001000;
        end
        e.tag     = tag;
        e.ctrl    = c;
        e.cnt     = m_count;
        e.cnt_sat = (m_count > 15) ? 4'd15 : 4'(m_count);
        sb_q.push_back(e);

        @(negedge clk);
        got_e = sb_q.pop_front();
        txn++;
        $display("txn %0d %s ctrl=%b cnt=%0d cnt_sat=%0d", txn, got_e.tag,
                 {pc_w, ifid_w, ifid_f, idex_f, ex_h, exmem_b, busy}, sc32, sc4);
        check({got_e.tag, ".ctrl"}, 32'({pc_w, ifid_w, ifid_f, idex_f, ex_h, exmem_b, busy}),
              32'(got_e.ctrl));
        check({got_e.tag, ".ctrl_sat"},
              32'({s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_ex_h, s_exmem_b, s_busy}),
              32'(got_e.ctrl));
        check({got_e.tag, ".cnt"}, sc32, got_e.cnt);
        check({got_e.tag, ".cnt_sat"}, 32'(sc4), 32'(got_e.cnt_sat));

        if (!rst_n) begin
            m_wait  = 1'b0;
            m_rem   = 0;
            m_count = 0;
        end else begin
            if (!c[6]) m_count++;
            if (m_wait) begin
                m_rem--;
                if (m_rem == 0) m_wait = 1'b0;
            end else if (fm) begin
                m_wait = 1'b1;
                m_rem  = LAT - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n   = 1'b0;
        m_wait  = 1'b0;
        m_rem   = 0;
        m_count = 0;
        @(posedge clk);
        #1;

        step("reset_hold");
        idle();
        step("idle");

        mr = 1'b1; rd = 5'd5; rs2 = 5'd5; use2 = 1'b1;
        step("int_lu");
        idle();
        step("after_lu");

        mr = 1'b1; rd = 5'd0; rs1 = 5'd0; use1 = 1'b1;
        step("x0_load");
        idle();
        fmr = 1'b1; rd = 5'd0; frs3 = 5'd0; use3 = 1'b1;
        step("fp_load_f0");
        idle();
        fmr = 1'b1; rd = 5'd3; rs1 = 5'd4; use1 = 1'b1;
        step("fp_load_nohit");
        idle();
        mr = 1'b1; rd = 5'd7; rs1 = 5'd7; use1 = 1'b0;
        step("unused_src");
        idle();

        fm = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("fpu_a%0d", i));
        for (int i = 0; i < 4; i++) step($sformatf("fpu_b%0d", i));
        idle();
        step("fpu_done");

        br = 1'b1; mr = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        step("br_lu");
        idle();
        br = 1'b1; fm = 1'b1;
        step("br_fpu");
        idle();
        br = 1'b1; mr = 1'b1; rd = 5'd9; rs2 = 5'd9; use2 = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("wait_ignore%0d", i));
        idle();
        step("post_wait");

        fm = 1'b1;
        step("rst_fpu_entry");
        idle();
        step("rst_wait1");
        rst_n = 1'b0;
        step("rst_wait2");
        idle();
        step("rst_after");
        step("rst_after2");

        mr = 1'b1; rd = 5'd2; rs1 = 5'd2; use1 = 1'b1;
        for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i));
        idle();
        step("sat_end");

        for (int i = 0; i < 60; i++) begin
            rst_n = ($urandom_range(0, 31) != 0);
            rd    = 5'($urandom_range(0, 3));
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            frs3  = 5'($urandom_range(0, 3));
            use1  = 1'($urandom_range(0, 1));
            use2  = 1'($urandom_range(0, 1));
            use3  = 1'($urandom_range(0, 1));
            mr    = 1'($urandom_range(0, 1));
            fmr   = 1'($urandom_range(0, 1));
            fm    = ($urandom_range(0, 7) == 0);
            br    = ($urandom_range(0, 5) == 0);
            step($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-side hazard controller for the five-stage RV32 integer/FP pipeline. Sits upstream of the EX-stage forwarding logic and resolves the hazards that forwarding cannot cover:
- load-use on integer and FP loads;
- multi-cycle FPU operations that must occupy EX for several cycles.

It drives the PC, IF/ID and ID/EX write-enable/flush controls and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- FPU_LATENCY, 4, total cycles a multi-cycle FPU op occupies EX; legal range 2..16
- CNT_W, 32, width of stall_count

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset (sampled on rising clk)
- ID_Rs1, ID_Rs2, ID_frs3  in  5 each  source register indices of the instruction in ID
- ID_useRs1, ID_useRs2, ID_useFrs3  in  1 each  the ID instruction actually reads that source
- EX_Rd  in  5  destination index of the instruction in EX
- EX_MemRead  in  1  EX instruction is an integer load
- EX_f_MemRead  in  1  EX instruction is an FP load (flw)
- EX_fpuMulti  in  1  EX instruction is a multi-cycle FPU op (fdiv, fsqrt, fmadd family)
- branch_taken  in  1  EX resolved a taken branch or jump
- PC_Write  out  1  1 = PC updates
- IFID_Write  out  1  1 = IF/ID register loads
- IFID_Flush  out  1  clear IF/ID to NOP
- IDEX_Flush  out  1  load bubble into ID/EX
- EX_Hold  out  1  ID/EX register holds its contents
- EXMEM_Bubble  out  1  load bubble into EX/MEM
- fpu_busy  out  1  FSM is in FPU_WAIT
- stall_count  out  CNT_W  cycles with PC_Write == 0 since reset

## Operation
- States: RUN and FPU_WAIT. A down-counter cnt is [3:0]. Stall/flush outputs are combinational from state and current inputs (Mealy). State, cnt and stall_count are registered.
- Reset (rst_n == 0 at a clk edge): state <= RUN, cnt <= 0, stall_count <= 0.
  - While rst_n is low, outputs are forced to PC_Write = 1, IFID_Write = 1, all flush/hold/bubble outputs = 0 and fpu_busy = 0, regardless of state.
- Load-use hazard (lu) is asserted when either of the following holds:
  - EX_MemRead, EX_Rd != 0, and EX_Rd equals any used ID source;
  - EX_f_MemRead, and EX_Rd equals any used ID source (f0 is a real register, so no zero exclusion).
- RUN priority, highest first:
  1. **EX_fpuMulti:** PC_Write = 0, IFID_Write = 0, EX_Hold = 1, EXMEM_Bubble = 1. Next state is FPU_WAIT with cnt <= FPU_LATENCY-2.
  2. **branch_taken:** IFID_Flush = 1, IDEX_Flush = 1, PC_Write = 1, IFID_Write = 1. Any lu is ignored.
  3. **lu:** PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1 for that cycle. State stays RUN, and lu clears naturally the next cycle.
  4. **Otherwise:** PC_Write = 1 and IFID_Write = 1; all other control outputs = 0.
- FPU_WAIT:
  - fpu_busy = 1.
  - While cnt != 0: same holds as RUN case 1; cnt decrements.
  - When cnt == 0: holds are deasserted and the FPU op advances to MEM at the next edge; state <= RUN.
  - EX_fpuMulti, branch_taken and lu are ignored throughout.
- EX_fpuMulti together with EX_MemRead/EX_f_MemRead is illegal; EX_fpuMulti wins.
- stall_count increments by 1 on each edge where PC_Write == 0 and rst_n == 1. It saturates at 2^CNT_W-1.

## Timing
- Load-use costs exactly 1 bubble; the consumer re-decodes in the next cycle and forwarding supplies the data from MEM.
- A multi-cycle FPU op entering EX at cycle t:
  - holds are asserted in cycles t .. t+FPU_LATENCY-2;
  - holds are released in cycle t+FPU_LATENCY-1;
  - the op is in MEM at t+FPU_LATENCY;
  - this costs FPU_LATENCY-1 stall cycles.
- A new multi-cycle op arriving in EX the cycle after release starts a fresh sequence with no gap cycle.
- Reset asserted mid-FPU_WAIT: outputs are released in the same cycle and the FSM is in RUN from the next edge. In-flight FPU state is the FPU's responsibility.

## Test plan
- **Integer load-use:** EX_MemRead = 1, EX_Rd = 5, ID_Rs2 = 5, ID_useRs2 = 1 -> one cycle of PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1; stall_count goes 0 -> 1.
- **x0 and FP load:** EX_MemRead = 1, EX_Rd = 0, ID_Rs1 = 0 -> no stall. EX_f_MemRead = 1, EX_Rd = 0, ID_frs3 = 0, ID_useFrs3 = 1 -> 1-cycle stall.
- **FPU wait:** FPU_LATENCY = 4, EX_fpuMulti held high for 4 cycles -> EX_Hold/EXMEM_Bubble high for 3 cycles, low in the 4th; fpu_busy high in cycles 2-4; stall_count += 3.
- **Priority:** branch_taken = 1 together with lu -> IFID_Flush = 1, IDEX_Flush = 1, PC_Write = 1, stall_count unchanged. branch_taken = 1 together with EX_fpuMulti -> FPU hold wins.
- **Reset mid-wait:** rst_n = 0 in the second FPU_WAIT cycle -> PC_Write = 1 and EX_Hold = 0 that cycle; state RUN and stall_count = 0 after the edge.
- **Saturation:** CNT_W = 4, 20 consecutive lu stalls -> stall_count stops at 15.
